// File: rtl/muldiv_sched.sv
// rtl/muldiv_sched.sv - RV64IM multiply/divide scheduler with shared iterative datapath
// Holds the pipeline while a 64-step shift-add multiply or restoring divide runs.
module muldiv_sched (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [1:0]  mul_en,
   input  logic [3:0]  div_en,
   input  logic [63:0] src_a,
   input  logic [63:0] src_b,
   input  logic        flush,
   output logic        stall,
   output logic        done,
   output logic [63:0] result
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [6:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;
   logic [63:0] opa_q, opa_d;
   logic [63:0] opb_q, opb_d;
   logic [63:0] result_q, result_d;
   logic        w_q, w_d;
   logic        sel_rem_q, sel_rem_d;
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;

   logic        accept;
   logic        is_mul;
   logic        op_w;
   logic        div_sgn;
   logic        div_uns;
   logic [63:0] a_prep, b_prep;
   logic [63:0] a_mag, b_mag;
   logic        div_zero;
   logic        div_ovf;
   logic [63:0] mul_sum;
   logic [64:0] rem_sh;
   logic [64:0] rem_diff;
   logic        rem_ge;
   logic [63:0] rem_nx, quo_nx;
   logic [63:0] q_fin, r_fin, div_res;

   function automatic logic [63:0] wfix(input logic [63:0] v, input logic w);
      return w ? {{32{v[31]}}, v[31:0]} : v;
   endfunction

   always_comb begin
      accept  = req_valid & (mul_en[0] | div_en[2]) & ~flush;
      is_mul  = mul_en[0];
      op_w    = is_mul ? mul_en[1] : div_en[3];
      div_uns = ~is_mul & div_en[0];
      div_sgn = ~is_mul & ~div_en[0];

      if (op_w) begin
         a_prep = div_uns ? {32'b0, src_a[31:0]} : {{32{src_a[31]}}, src_a[31:0]};
         b_prep = div_uns ? {32'b0, src_b[31:0]} : {{32{src_b[31]}}, src_b[31:0]};
      end else begin
         a_prep = src_a;
         b_prep = src_b;
      end

      a_mag    = (div_sgn & a_prep[63]) ? -a_prep : a_prep;
      b_mag    = (div_sgn & b_prep[63]) ? -b_prep : b_prep;
      div_zero = (b_prep == 64'd0);
      div_ovf  = div_sgn & (b_prep == {64{1'b1}}) &
                 (a_prep == (op_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
   end

   // One iteration of each algorithm; rem_sh < 2*divisor, so bit 64 of the difference is the borrow.
   always_comb begin
      mul_sum  = opb_q[0] ? (acc_q + opa_q) : acc_q;
      rem_sh   = {acc_q, opa_q[63]};
      rem_diff = rem_sh - {1'b0, opb_q};
      rem_ge   = ~rem_diff[64];
      rem_nx   = rem_ge ? rem_diff[63:0] : rem_sh[63:0];
      quo_nx   = {opa_q[62:0], rem_ge};
      q_fin    = qneg_q ? -quo_nx : quo_nx;
      r_fin    = rneg_q ? -rem_nx : rem_nx;
      div_res  = sel_rem_q ? r_fin : q_fin;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      result_d  = result_q;
      w_d       = w_q;
      sel_rem_d = sel_rem_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               cnt_d     = 7'd0;
               w_d       = op_w;
               sel_rem_d = div_en[1];
               qneg_d    = div_sgn & (a_prep[63] ^ b_prep[63]);
               rneg_d    = div_sgn & a_prep[63];
               acc_d     = 64'd0;
               if (is_mul) begin
                  opa_d   = a_prep;
                  opb_d   = b_prep;
                  state_d = S_MUL;
               end else if (div_zero) begin
                  result_d = wfix(div_en[1] ? a_prep : {64{1'b1}}, op_w);
                  state_d  = S_DONE;
               end else if (div_ovf) begin
                  result_d = wfix(div_en[1] ? 64'd0 : a_prep, op_w);
                  state_d  = S_DONE;
               end else begin
                  opa_d   = a_mag;
                  opb_d   = b_mag;
                  state_d = S_DIV;
               end
            end
         end
         S_MUL: begin
            acc_d = mul_sum;
            opa_d = {opa_q[62:0], 1'b0};
            opb_d = {1'b0, opb_q[63:1]};
            cnt_d = cnt_q + 7'd1;
            if (cnt_q == 7'd63) begin
               result_d = wfix(mul_sum, w_q);
               state_d  = S_DONE;
            end
         end
         S_DIV: begin
            acc_d = rem_nx;
            opa_d = quo_nx;
            cnt_d = cnt_q + 7'd1;
            if (cnt_q == 7'd63) begin
               result_d = wfix(div_res, w_q);
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A killed operation must not leave its result behind either.
      if (flush) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 7'd0;
         acc_q     <= 64'd0;
         opa_q     <= 64'd0;
         opb_q     <= 64'd0;
         result_q  <= 64'd0;
         w_q       <= 1'b0;
         sel_rem_q <= 1'b0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         result_q  <= result_d;
         w_q       <= w_d;
         sel_rem_q <= sel_rem_d;
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
      end
   end

   assign stall  = ((state_q == S_IDLE) & accept) | (state_q == S_MUL) | (state_q == S_DIV);
   assign done   = (state_q == S_DONE);
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// tb/tb_muldiv_sched.sv - scoreboard bench for muldiv_sched against an ISA-level M-extension model
module tb_muldiv_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [1:0]  mul_en;
   logic [3:0]  div_en;
   logic [63:0] src_a;
   logic [63:0] src_b;
   logic        flush;
   logic        stall;
   logic        done;
   logic [63:0] result;

   always #5 clk = ~clk;

   muldiv_sched dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .mul_en    (mul_en),
      .div_en    (div_en),
      .src_a     (src_a),
      .src_b     (src_b),
      .flush     (flush),
      .stall     (stall),
      .done      (done),
      .result    (result)
   );

   typedef struct {
      logic [63:0] res;
      int          lat;
      int          acc;
      string       tag;
   } exp_t;

   exp_t sbq[$];
   int   n_vec     = 0;
   int   n_bad     = 0;
   int   cyc       = 0;
   int   stall_cnt = 0;
   int   n_done    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] sx32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   // RISC-V M-extension semantics; latency is 1 for the zero-divisor and overflow cases.
   function automatic logic [63:0] model(input logic [1:0] me, input logic [3:0] de,
                                         input logic [63:0] a, input logic [63:0] b,
                                         output int lat);
      logic [63:0] p, q64, r64;
      logic [31:0] q32, r32, ua, ub;
      int          sa, sbv;
      longint      la, lb;
      lat = 65;
      if (me[0]) begin
         p = a * b;
         return me[1] ? sx32(p[31:0]) : p;
      end
      if (de[3]) begin
         ua  = a[31:0];
         ub  = b[31:0];
         sa  = $signed(a[31:0]);
         sbv = $signed(b[31:0]);
         if (ub == 32'd0) begin
            q32 = 32'hFFFF_FFFF;
            r32 = ua;
            lat = 1;
         end else if (de[0]) begin
            q32 = ua / ub;
            r32 = ua % ub;
         end else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) begin
            q32 = ua;
            r32 = 32'd0;
            lat = 1;
         end else begin
            q32 = 32'(sa / sbv);
            r32 = 32'(sa % sbv);
         end
         return sx32(de[1] ? r32 : q32);
      end
      la = $signed(a);
      lb = $signed(b);
      if (b == 64'd0) begin
         q64 = {64{1'b1}};
         r64 = a;
         lat = 1;
      end else if (de[0]) begin
         q64 = a / b;
         r64 = a % b;
      end else if (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) begin
         q64 = a;
         r64 = 64'd0;
         lat = 1;
      end else begin
         q64 = 64'(la / lb);
         r64 = 64'(la % lb);
      end
      return de[1] ? r64 : q64;
   endfunction

   function automatic logic [63:0] pick();
      logic [63:0] v;
      case ($urandom_range(0, 5))
         0: v = {$urandom, $urandom};
         1: v = 64'($urandom_range(0, 40)) - 64'd20;
         2: v = 64'd0;
         3: v = 64'h8000_0000_0000_0000;
         4: v = {64{1'b1}};
         default: v = {$urandom, 32'h8000_0000};
      endcase
      return v;
   endfunction

   // Monitor: pops one expectation per done pulse and checks value, latency and stall length.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (stall) stall_cnt++;
            if (done) begin
               n_done++;
               if (sbq.size() == 0) begin
                  n_vec++;
                  n_bad++;
                  $display("FAIL spurious_done: got done=1 at cycle %0d, expected no done", cyc);
               end else begin
                  e = sbq.pop_front();
                  chk({e.tag, "_result"}, result, e.res);
                  chk({e.tag, "_latency"}, 64'(cyc - e.acc), 64'(e.lat));
                  chk({e.tag, "_stall_cycles"}, 64'(stall_cnt), 64'(e.lat));
               end
               stall_cnt = 0;
            end
         end
      end
   end

   task automatic do_op(input string tag, input logic [1:0] me, input logic [3:0] de,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] er, input int el, input bit b2b);
      exp_t e;
      int   k;
      if (!b2b) begin
         req_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      req_valid = 1'b1;
      mul_en    = me;
      div_en    = de;
      src_a     = a;
      src_b     = b;
      e.res = er;
      e.lat = el;
      e.acc = cyc + (b2b ? 1 : 0);
      e.tag = tag;
      sbq.push_back(e);
      for (k = 0; k < 200; k++) begin
         @(posedge clk);
         #1;
         if (done) break;
      end
      if (k == 200) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s_timeout: got no done in 200 cycles, expected done", tag);
         sbq.delete();
      end
      req_valid = 1'b0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got no end of test, expected $finish");
      $fatal(1);
   end

   initial begin : stim
      logic [1:0]  me;
      logic [3:0]  de;
      logic [63:0] a, b, er;
      int          el, d0;

      reset     = 1'b1;
      req_valid = 1'b0;
      flush     = 1'b0;
      mul_en    = 2'b00;
      div_en    = 4'b0000;
      src_a     = 64'd0;
      src_b     = 64'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_stall", 64'(stall), 64'd0);
      chk("reset_result", result, 64'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      do_op("mul", 2'b01, 4'b0000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 1'b0);
      do_op("div", 2'b00, 4'b0100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b0);
      do_op("rem", 2'b00, 4'b0110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0);
      do_op("divu", 2'b00, 4'b0101, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'h7FFF_FFFF_FFFF_FFFC, 65, 1'b0);
      do_op("divu_z", 2'b00, 4'b0101, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
      do_op("remu_z", 2'b00, 4'b0111, 64'h1234, 64'd0, 64'h1234, 1, 1'b0);
      do_op("remw_z", 2'b00, 4'b1110, 64'h8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 1, 1'b0);
      do_op("div_ovf", 2'b00, 4'b0100, 64'h8000_0000_0000_0000, {64{1'b1}}, 64'h8000_0000_0000_0000, 1, 1'b0);
      do_op("rem_ovf", 2'b00, 4'b0110, 64'h8000_0000_0000_0000, {64{1'b1}}, 64'd0, 1, 1'b0);
      do_op("divw_ovf", 2'b00, 4'b1100, 64'h8000_0000, {64{1'b1}}, 64'hFFFF_FFFF_8000_0000, 1, 1'b0);
      do_op("mulw", 2'b11, 4'b0000, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1'b0);
      do_op("divuw", 2'b00, 4'b1101, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0);
      do_op("both_en", 2'b01, 4'b0100, 64'd6, 64'd7, 64'd42, 65, 1'b0);

      // Back-to-back: next request is presented during done, so it is accepted one bubble later.
      do_op("b2b0", 2'b00, 4'b0101, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
      do_op("b2b1", 2'b00, 4'b0111, 64'h1234, 64'd0, 64'h1234, 1, 1'b1);
      do_op("b2b2", 2'b01, 4'b0000, 64'd5, 64'd9, 64'd45, 65, 1'b1);

      req_valid = 1'b1;
      mul_en    = 2'b10;
      div_en    = 4'b1011;
      repeat (4) begin
         @(posedge clk);
         #1;
         chk("ignored_stall", 64'(stall), 64'd0);
      end

      mul_en = 2'b01;
      flush  = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("flush_idle_stall", 64'(stall), 64'd0);
      end
      req_valid = 1'b0;
      flush     = 1'b0;
      @(posedge clk);
      #1;

      req_valid = 1'b1;
      mul_en    = 2'b01;
      div_en    = 4'b0000;
      src_a     = 64'd3;
      src_b     = 64'd4;
      @(posedge clk);
      repeat (10) @(posedge clk);
      #1;
      chk("flush_busy_stall", 64'(stall), 64'd1);
      flush     = 1'b1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_stall", 64'(stall), 64'd0);
      chk("flush_done", 64'(done), 64'd0);
      d0 = n_done;
      repeat (70) @(posedge clk);
      #1;
      chk("flush_no_done", 64'(n_done), 64'(d0));
      stall_cnt = 0;

      req_valid = 1'b1;
      mul_en    = 2'b00;
      div_en    = 4'b0100;
      src_a     = 64'd100;
      src_b     = 64'd7;
      repeat (21) @(posedge clk);
      #1;
      reset     = 1'b1;
      req_valid = 1'b0;
      #1;
      chk("async_reset_result", result, 64'd0);
      chk("async_reset_done", 64'(done), 64'd0);
      chk("async_reset_stall", 64'(stall), 64'd0);
      @(posedge clk);
      #1;
      reset     = 1'b0;
      stall_cnt = 0;

      for (int i = 0; i < 40; i++) begin
         me = 2'($urandom_range(0, 3));
         de = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) != 0) me[0] = 1'b0;
         if (!me[0]) de[2] = 1'b1;
         a  = pick();
         b  = pick();
         er = model(me, de, a, b, el);
         do_op($sformatf("rnd%0d", i), me, de, a, b, er, el, (i > 0) && ($urandom_range(0, 3) == 0));
      end

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
